apb_fsm_controller: RTL and testbench
=====================================

// Module: apb_fsm_controller
// PURPOSE
//  AHB-to-APB bridge master FSM: accepts AHB-Lite transfers, decodes a 3-slave APB window,
//  sequences APB SETUP/ENABLE phases and stalls AHB via hready_out.
//  Sits directly upstream of the APB interface stage: drives its penable/pwrite/pwdata/paddr/psel
//  and returns its pr_data to the AHB side as hrdata.
// PARAMETERS
//  ADDR_W    32            address width
//  DATA_W    32            data width
//  NUM_SLV   3             APB slaves; psel is one-hot NUM_SLV bits
//  BASE      32'h8000_0000 start of APB window
//  SLV_SPAN  32'h0400_0000 bytes per slave; slave i = [BASE+i*SPAN, BASE+(i+1)*SPAN)
// PORTS
//  hclk        in   1        clock, rising edge
//  hresetn     in   1        asynchronous active-low reset
//  htrans      in   2        AHB transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
//  hready_in   in   1        AHB bus ready, qualifies address phase
//  hwrite      in   1        AHB direction, address phase
//  haddr       in   ADDR_W   AHB address, address phase
//  hwdata      in   DATA_W   AHB write data, data phase
//  prdata      in   DATA_W   read data from APB interface stage
//  hready_out  out  1        bridge ready to AHB
//  hresp       out  2        always 2'b00 (OKAY)
//  hrdata      out  DATA_W   read data to AHB
//  psel        out  NUM_SLV  one-hot APB select, registered
//  penable     out  1        APB enable, registered
//  pwrite      out  1        APB direction, registered
//  paddr       out  ADDR_W   APB address, registered
//  pwdata      out  DATA_W   APB write data, registered
// BEHAVIOUR
//  valid = hready_in & htrans[1] & haddr in [BASE, BASE+NUM_SLV*SPAN); sel = one-hot slave index.
//  Out-of-window, IDLE and BUSY transfers: ignored, no APB activity, hresp stays OKAY.
//  States: ST_IDLE, ST_WWAIT, ST_SETUP, ST_ENABLE.
//  Reset: state=ST_IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata_q=0.
//   All registers clear immediately on hresetn low, including mid-transfer.
//  hready_out is combinational: 1 in ST_IDLE and ST_ENABLE, 0 in ST_WWAIT and ST_SETUP.
//  ST_IDLE:
//   valid & !hwrite -> ST_SETUP; load paddr=haddr, psel=sel, pwrite=0.
//   valid &  hwrite -> ST_WWAIT; load paddr=haddr, pwrite=1; hold the select internally, psel stays 0.
//   Otherwise stay in ST_IDLE.
//  ST_WWAIT (AHB data phase, stalled): load pwdata=hwdata, psel=held sel; -> ST_SETUP.
//  ST_SETUP: psel asserted, penable=0; -> ST_ENABLE unconditionally; set penable=1.
//  ST_ENABLE: psel and penable both 1; the transfer completes at the end of this cycle.
//   Read: hrdata = prdata combinationally; prdata is also captured into hrdata_q.
//   Next state (back-to-back, because hready_out=1 here):
//    valid & !hwrite -> ST_SETUP, loaded as in ST_IDLE.
//    valid &  hwrite -> ST_WWAIT, loaded as in ST_IDLE.
//    otherwise -> ST_IDLE with psel=0, penable=0.
//  hrdata = (ST_ENABLE & !pwrite) ? prdata : hrdata_q; holds the last read value otherwise.
//  Latency from address-phase edge: read psel+1, penable+2, 3 cycles per read.
//   Write psel+2, penable+3, 4 cycles per write.
//  paddr, pwrite and pwdata are stable from SETUP through ENABLE; they change only on a new transfer.
//  Top address boundary BASE+NUM_SLV*SPAN and BASE-1 decode as not valid.
// STRUCTURE
//  Package apb_bridge_pkg holds: state encodings, HTRANS_* codes, BASE/SLV_SPAN defaults, HRESP_OKAY.
//  Sub-module ahb_addr_decode: combinational; haddr/htrans/hready_in -> valid, sel[NUM_SLV-1:0].
//  FSM, APB output registers and hrdata_q stay in this module.
// TESTING
//  1. Reset: hresetn=0 mid-ENABLE -> psel=0, penable=0, hready_out=1 in the same cycle; FSM in ST_IDLE.
//  2. Read 0x8000_0010 (NONSEQ), prdata=0xA5:
//     psel=001 at +1, penable=1 at +2 with hready_out=1 and hrdata=0xA5; hrdata holds 0xA5 afterwards.
//  3. Write 0x8400_0004 with hwdata=0xDEAD_BEEF:
//     hready_out=0 for 2 cycles; psel=010, pwrite=1, pwdata=0xDEADBEEF at +2; penable at +3.
//  4. Back-to-back read 0x8800_0000 then write 0x8000_0000:
//     ST_ENABLE goes directly to ST_WWAIT; psel drops for exactly one cycle; psel=100 then 001.
//  5. Decode edges: haddr 0x7FFF_FFFC, 0x8C00_0000, and htrans=BUSY at 0x8000_0000 -> no psel, hready_out stays 1.
//  6. hready_in=0 with NONSEQ at a valid address -> ignored; the transfer starts only in the cycle hready_in=1.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// ============================================================================
// Module : apb_bridge_pkg
// Brief  : Shared encodings and window defaults for the AHB-to-APB bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package apb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WWAIT  = 2'd1,
      ST_SETUP  = 2'd2,
      ST_ENABLE = 2'd3
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY = 2'b00;

   localparam logic [31:0] APB_BASE_DEF     = 32'h8000_0000;
   localparam logic [31:0] APB_SLV_SPAN_DEF = 32'h0400_0000;

endpackage

`default_nettype wire

// File: rtl/apb_fsm_controller_if.sv
// ============================================================================
// Module : apb_fsm_controller_if
// Brief  : AHB-Lite slave side and APB master side signals of the bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface apb_fsm_controller_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 3
);
   logic [1:0]         htrans;
   logic               hready_in;
   logic               hwrite;
   logic [ADDR_W-1:0]  haddr;
   logic [DATA_W-1:0]  hwdata;
   logic [DATA_W-1:0]  prdata;
   logic               hready_out;
   logic [1:0]         hresp;
   logic [DATA_W-1:0]  hrdata;
   logic [NUM_SLV-1:0] psel;
   logic               penable;
   logic               pwrite;
   logic [ADDR_W-1:0]  paddr;
   logic [DATA_W-1:0]  pwdata;

   // master: the bridge itself; slave: the surrounding AHB/APB environment
   modport master (
      input  htrans, hready_in, hwrite, haddr, hwdata, prdata,
      output hready_out, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output htrans, hready_in, hwrite, haddr, hwdata, prdata,
      input  hready_out, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );
endinterface

`default_nettype wire

// File: rtl/ahb_addr_decode.sv
// ============================================================================
// Module : ahb_addr_decode
// Brief  : Qualifies an AHB address phase and one-hot decodes the APB slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ahb_addr_decode
   import apb_bridge_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              NUM_SLV  = 3,
   parameter logic [ADDR_W-1:0] BASE     = APB_BASE_DEF,
   parameter logic [ADDR_W-1:0] SLV_SPAN = APB_SLV_SPAN_DEF
) (
   input  wire logic [1:0]         htrans_i,
   input  wire logic               hready_in_i,
   input  wire logic [ADDR_W-1:0]  haddr_i,
   output      logic               valid_o,
   output      logic [NUM_SLV-1:0] sel_o
);

   localparam logic [ADDR_W:0] SPAN_X = {1'b0, SLV_SPAN};
   localparam logic [ADDR_W:0] WIN_X  = (ADDR_W+1)'(NUM_SLV) * SPAN_X;

   logic [ADDR_W:0] offset;
   logic            active;
   logic            in_win;

   // Extra MSB of the offset is the borrow: set when haddr sits below BASE.
   assign offset  = {1'b0, haddr_i} - {1'b0, BASE};
   assign active  = (htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ);
   assign in_win  = !offset[ADDR_W] && (offset < WIN_X);
   assign valid_o = hready_in_i && active && in_win;

   for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
      localparam logic [ADDR_W:0] LO_X = (ADDR_W+1)'(i) * SPAN_X;
      localparam logic [ADDR_W:0] HI_X = LO_X + SPAN_X;
      assign sel_o[i] = valid_o && (offset >= LO_X) && (offset < HI_X);
   end

endmodule

`default_nettype wire

// File: rtl/apb_fsm_controller.sv
// ============================================================================
// Module : apb_fsm_controller
// Brief  : AHB-Lite to APB bridge master FSM with SETUP/ENABLE sequencing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_fsm_controller
   import apb_bridge_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                NUM_SLV  = 3,
   parameter logic [ADDR_W-1:0] BASE     = APB_BASE_DEF,
   parameter logic [ADDR_W-1:0] SLV_SPAN = APB_SLV_SPAN_DEF
) (
   input wire logic               hclk,
   input wire logic               hresetn,
   apb_fsm_controller_if.master   bus
);

   state_t             state_q,    state_d;
   logic [NUM_SLV-1:0] psel_q,     psel_d;
   logic [NUM_SLV-1:0] selhold_q,  selhold_d;
   logic               penable_q,  penable_d;
   logic               pwrite_q,   pwrite_d;
   logic [ADDR_W-1:0]  paddr_q,    paddr_d;
   logic [DATA_W-1:0]  pwdata_q,   pwdata_d;
   logic [DATA_W-1:0]  hrdata_q,   hrdata_d;

   logic               valid;
   logic [NUM_SLV-1:0] sel;

   ahb_addr_decode #(
      .ADDR_W   (ADDR_W),
      .NUM_SLV  (NUM_SLV),
      .BASE     (BASE),
      .SLV_SPAN (SLV_SPAN)
   ) u_decode (
      .htrans_i    (bus.htrans),
      .hready_in_i (bus.hready_in),
      .haddr_i     (bus.haddr),
      .valid_o     (valid),
      .sel_o       (sel)
   );

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= ST_IDLE;
         psel_q    <= '0;
         selhold_q <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         hrdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         selhold_q <= selhold_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         hrdata_q  <= hrdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      selhold_d = selhold_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      hrdata_d  = hrdata_q;

      case (state_q)
         ST_IDLE: begin
            if (valid) begin
               paddr_d   = bus.haddr;
               pwrite_d  = bus.hwrite;
               selhold_d = sel;
               psel_d    = bus.hwrite ? '0 : sel;
               state_d   = bus.hwrite ? ST_WWAIT : ST_SETUP;
            end
         end
         ST_WWAIT: begin
            pwdata_d = bus.hwdata;
            psel_d   = selhold_q;
            state_d  = ST_SETUP;
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ENABLE;
         end
         ST_ENABLE: begin
            if (!pwrite_q) begin
               hrdata_d = bus.prdata;
            end
            penable_d = 1'b0;
            // A write follow-on drops psel for the WWAIT cycle; a read keeps it live.
            if (valid) begin
               paddr_d   = bus.haddr;
               pwrite_d  = bus.hwrite;
               selhold_d = sel;
               psel_d    = bus.hwrite ? '0 : sel;
               state_d   = bus.hwrite ? ST_WWAIT : ST_SETUP;
            end else begin
               psel_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.hready_out = (state_q == ST_IDLE) || (state_q == ST_ENABLE);
   assign bus.hresp      = HRESP_OKAY;
   assign bus.hrdata     = ((state_q == ST_ENABLE) && !pwrite_q) ? bus.prdata : hrdata_q;
   assign bus.psel       = psel_q;
   assign bus.penable    = penable_q;
   assign bus.pwrite     = pwrite_q;
   assign bus.paddr      = paddr_q;
   assign bus.pwdata     = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_fsm_controller.sv
// ============================================================================
// Module : tb_apb_fsm_controller
// Brief  : Directed self-checking bench for the AHB-to-APB bridge FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_fsm_controller;
   import apb_bridge_pkg::*;

   logic hclk;
   logic hresetn;
   int   n_pass;
   int   n_tot;

   apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bus ();

   apb_fsm_controller #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .NUM_SLV  (3),
      .BASE     (32'h8000_0000),
      .SLV_SPAN (32'h0400_0000)
   ) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to just after the next rising edge; inputs and checks happen here.
   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic ahb(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic rdy);
      bus.htrans    = tr;
      bus.hwrite    = wr;
      bus.haddr     = a;
      bus.hready_in = rdy;
   endtask

   task automatic ahb_idle();
      ahb(HTRANS_IDLE, 1'b0, 32'h0, 1'b1);
   endtask

   logic [31:0] edge_addr [3];
   logic [1:0]  edge_tr   [3];

   initial begin
      n_pass = 0;
      n_tot  = 0;
      hresetn = 1'b0;
      ahb_idle();
      bus.hwdata = '0;
      bus.prdata = '0;
      #1;
      chk("rst_psel",    64'(bus.psel), 64'h0);
      chk("rst_penable", 64'(bus.penable), 64'h0);
      chk("rst_hready",  64'(bus.hready_out), 64'h1);
      chk("rst_hresp",   64'(bus.hresp), 64'h0);
      chk("rst_paddr",   64'(bus.paddr), 64'h0);
      chk("rst_hrdata",  64'(bus.hrdata), 64'h0);
      tick();
      tick();
      hresetn = 1'b1;

      // Single read to slave 0
      ahb(HTRANS_NONSEQ, 1'b0, 32'h8000_0010, 1'b1);
      bus.prdata = 32'h0000_00A5;
      chk("rd_a_hready", 64'(bus.hready_out), 64'h1);
      tick();
      ahb_idle();
      chk("rd_setup_psel",    64'(bus.psel), 64'b001);
      chk("rd_setup_penable", 64'(bus.penable), 64'h0);
      chk("rd_setup_hready",  64'(bus.hready_out), 64'h0);
      chk("rd_setup_paddr",   64'(bus.paddr), 64'h8000_0010);
      chk("rd_setup_pwrite",  64'(bus.pwrite), 64'h0);
      tick();
      chk("rd_en_psel",    64'(bus.psel), 64'b001);
      chk("rd_en_penable", 64'(bus.penable), 64'h1);
      chk("rd_en_hready",  64'(bus.hready_out), 64'h1);
      chk("rd_en_hrdata",  64'(bus.hrdata), 64'hA5);
      tick();
      bus.prdata = 32'h0000_0055;
      #1;
      chk("rd_done_psel",    64'(bus.psel), 64'h0);
      chk("rd_done_penable", 64'(bus.penable), 64'h0);
      chk("rd_hold_hrdata",  64'(bus.hrdata), 64'hA5);

      // Single write to slave 1
      ahb(HTRANS_NONSEQ, 1'b1, 32'h8400_0004, 1'b1);
      tick();
      ahb_idle();
      bus.hwdata = 32'hDEAD_BEEF;
      chk("wr_wait_hready", 64'(bus.hready_out), 64'h0);
      chk("wr_wait_psel",   64'(bus.psel), 64'h0);
      chk("wr_wait_pwrite", 64'(bus.pwrite), 64'h1);
      chk("wr_wait_state",  64'(dut.state_q), 64'(ST_WWAIT));
      tick();
      bus.hwdata = 32'h1111_2222;
      chk("wr_setup_hready",  64'(bus.hready_out), 64'h0);
      chk("wr_setup_psel",    64'(bus.psel), 64'b010);
      chk("wr_setup_pwdata",  64'(bus.pwdata), 64'hDEAD_BEEF);
      chk("wr_setup_penable", 64'(bus.penable), 64'h0);
      chk("wr_setup_paddr",   64'(bus.paddr), 64'h8400_0004);
      tick();
      chk("wr_en_penable", 64'(bus.penable), 64'h1);
      chk("wr_en_hready",  64'(bus.hready_out), 64'h1);
      chk("wr_en_pwdata",  64'(bus.pwdata), 64'hDEAD_BEEF);
      chk("wr_en_hrdata",  64'(bus.hrdata), 64'hA5);
      tick();
      chk("wr_done_psel", 64'(bus.psel), 64'h0);

      // Back-to-back read (slave 2) then write (slave 0)
      ahb(HTRANS_NONSEQ, 1'b0, 32'h8800_0000, 1'b1);
      bus.prdata = 32'h0000_1234;
      tick();
      ahb_idle();
      chk("b2b_rd_psel", 64'(bus.psel), 64'b100);
      tick();
      ahb(HTRANS_NONSEQ, 1'b1, 32'h8000_0000, 1'b1);
      chk("b2b_en_psel",   64'(bus.psel), 64'b100);
      chk("b2b_en_hrdata", 64'(bus.hrdata), 64'h1234);
      tick();
      ahb_idle();
      bus.hwdata = 32'hCAFE_0001;
      chk("b2b_state_wwait", 64'(dut.state_q), 64'(ST_WWAIT));
      chk("b2b_gap_psel",    64'(bus.psel), 64'h0);
      chk("b2b_gap_penable", 64'(bus.penable), 64'h0);
      chk("b2b_hold_hrdata", 64'(bus.hrdata), 64'h1234);
      tick();
      chk("b2b_wr_psel",   64'(bus.psel), 64'b001);
      chk("b2b_wr_pwdata", 64'(bus.pwdata), 64'hCAFE_0001);
      chk("b2b_wr_paddr",  64'(bus.paddr), 64'h8000_0000);
      tick();
      chk("b2b_wr_penable", 64'(bus.penable), 64'h1);
      tick();
      chk("b2b_idle_state", 64'(dut.state_q), 64'(ST_IDLE));

      // Decode edges that must be ignored
      edge_addr[0] = 32'h7FFF_FFFC; edge_tr[0] = HTRANS_NONSEQ;
      edge_addr[1] = 32'h8C00_0000; edge_tr[1] = HTRANS_NONSEQ;
      edge_addr[2] = 32'h8000_0000; edge_tr[2] = HTRANS_BUSY;
      for (int i = 0; i < 3; i++) begin
         ahb(edge_tr[i], 1'b0, edge_addr[i], 1'b1);
         tick();
         chk($sformatf("edge%0d_psel", i),   64'(bus.psel), 64'h0);
         chk($sformatf("edge%0d_hready", i), 64'(bus.hready_out), 64'h1);
         chk($sformatf("edge%0d_state", i),  64'(dut.state_q), 64'(ST_IDLE));
      end

      // Last word inside the window selects slave 2
      ahb(HTRANS_SEQ, 1'b0, 32'h8BFF_FFFC, 1'b1);
      tick();
      ahb_idle();
      chk("top_in_psel", 64'(bus.psel), 64'b100);
      tick();
      tick();

      // hready_in low holds off the transfer
      ahb(HTRANS_NONSEQ, 1'b0, 32'h8000_0000, 1'b0);
      tick();
      chk("nrdy_psel",  64'(bus.psel), 64'h0);
      chk("nrdy_state", 64'(dut.state_q), 64'(ST_IDLE));
      bus.hready_in = 1'b1;
      tick();
      ahb_idle();
      chk("rdy_psel", 64'(bus.psel), 64'b001);
      tick();

      // Asynchronous reset in the middle of ENABLE
      bus.prdata = 32'h0000_7777;
      chk("pre_rst_penable", 64'(bus.penable), 64'h1);
      hresetn = 1'b0;
      #1;
      chk("arst_psel",    64'(bus.psel), 64'h0);
      chk("arst_penable", 64'(bus.penable), 64'h0);
      chk("arst_hready",  64'(bus.hready_out), 64'h1);
      chk("arst_state",   64'(dut.state_q), 64'(ST_IDLE));
      chk("arst_hrdata",  64'(bus.hrdata), 64'h0);
      chk("arst_paddr",   64'(bus.paddr), 64'h0);
      tick();
      hresetn = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

`default_nettype wire
